aes_encipher_round_ctrl: RTL and testbench



---
 rtl/aes_encipher_round_ctrl.sv | 123 ++++++++++++
 tb/tb_aes_encipher_round_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/aes_encipher_round_ctrl.sv
// aes_encipher_round_ctrl: iterative AES-128/256 encipher round datapath and controller (optional busy_err port via AES_ENC_BUSY_ERR_EN)
module aes_encipher_round_ctrl #(
  parameter int AES_128_NUM_ROUNDS = 10,
  parameter int AES_256_NUM_ROUNDS = 14
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         next,
  input  logic         keylen,
  output logic [3:0]   round,
  input  logic [127:0] round_key,
  output logic [31:0]  sboxw,
  input  logic [31:0]  new_sboxw,
  input  logic [127:0] block,
  output logic [127:0] new_block,
  output logic         ready
`ifdef AES_ENC_BUSY_ERR_EN
  ,
  output logic         busy_err
`endif
);
  typedef enum logic [1:0] {IDLE, INIT, SBOX, MAIN} state_t;
  state_t state_q;
  logic [127:0] block_q, sub_d, rnd_d, sr;
  logic [3:0] round_ctr_q, nr;
  logic [1:0] sword_ctr_q;
  logic keylen_q, ready_q, more;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    return {mix_col(s[127:96]), mix_col(s[95:64]), mix_col(s[63:32]), mix_col(s[31:0])};
  endfunction

  assign round     = round_ctr_q;
  assign new_block = block_q;
  assign ready     = ready_q;

  // S-box word select/replace and the rest of the round (final round skips MixColumns)
  always_comb begin
    nr    = keylen_q ? 4'(AES_256_NUM_ROUNDS) : 4'(AES_128_NUM_ROUNDS);
    more  = round_ctr_q < nr;
    sboxw = sword_ctr_q == 2'd0 ? block_q[127:96] :
            sword_ctr_q == 2'd1 ? block_q[95:64]  :
            sword_ctr_q == 2'd2 ? block_q[63:32]  : block_q[31:0];
    sub_d = {sword_ctr_q == 2'd0 ? new_sboxw : block_q[127:96],
             sword_ctr_q == 2'd1 ? new_sboxw : block_q[95:64],
             sword_ctr_q == 2'd2 ? new_sboxw : block_q[63:32],
             sword_ctr_q == 2'd3 ? new_sboxw : block_q[31:0]};
    sr    = shift_rows(block_q);
    rnd_d = (more ? mix_columns(sr) : sr) ^ round_key;
  end

  // Round controller: IDLE -> INIT -> (SBOX x4 -> MAIN) x Nr -> IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ready_q     <= 1'b1;
      block_q     <= '0;
      round_ctr_q <= '0;
      sword_ctr_q <= '0;
      keylen_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (next) begin
          keylen_q <= keylen;
          ready_q  <= 1'b0;
          state_q  <= INIT;
        end
        INIT: begin
          block_q     <= block ^ round_key;
          round_ctr_q <= 4'd1;
          state_q     <= SBOX;
        end
        SBOX: begin
          block_q     <= sub_d;
          sword_ctr_q <= sword_ctr_q + 2'd1;
          if (sword_ctr_q == 2'd3) state_q <= MAIN;
        end
        MAIN: begin
          block_q <= rnd_d;
          if (more) begin
            round_ctr_q <= round_ctr_q + 4'd1;
            state_q     <= SBOX;
          end else begin
            round_ctr_q <= '0;
            ready_q     <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef AES_ENC_BUSY_ERR_EN
  // Flag a next request that arrives while a block is in flight
  always_ff @(posedge clk) begin
    if (reset) busy_err <= 1'b0;
    else       busy_err <= next && state_q != IDLE;
  end
`endif
endmodule

// File: tb/tb_aes_encipher_round_ctrl.sv
// tb_aes_encipher_round_ctrl: directed FIPS-197 vectors with modelled key memory and S-box
module tb_aes_encipher_round_ctrl;
  logic clk = 1'b0;
  logic reset, next, keylen, ready;
  logic [3:0] round;
  logic [127:0] round_key, block, new_block;
  logic [31:0] sboxw, new_sboxw;
`ifdef AES_ENC_BUSY_ERR_EN
  logic busy_err;
`endif
  logic [7:0] sb [256];
  logic [127:0] rk [16];
  int total = 0, passed = 0;

  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;

  aes_encipher_round_ctrl dut (
    .clk(clk), .reset(reset), .next(next), .keylen(keylen), .round(round),
    .round_key(round_key), .sboxw(sboxw), .new_sboxw(new_sboxw), .block(block),
    .new_block(new_block), .ready(ready)
`ifdef AES_ENC_BUSY_ERR_EN
    , .busy_err(busy_err)
`endif
  );

  always #5 clk = ~clk;
  assign round_key = rk[round];
  assign new_sboxw = {sb[sboxw[31:24]], sb[sboxw[23:16]], sb[sboxw[15:8]], sb[sboxw[7:0]]};

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
  endfunction

  task automatic expand(input logic [255:0] key, input logic kl);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0] rc = 8'h01;
    int nk = kl ? 8 : 4;
    int nr = kl ? 14 : 10;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk == 8 && i % nk == 4) t = subw(t);
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++)
      if (r <= nr) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      else rk[r] = '0;
  endtask

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  // Called in the INIT cycle (c=1); follows the block to ready, optionally injecting a busy next or a reset
  task automatic track(input string tag, input logic [127:0] exp, input int lat,
                       input bit hold, input int busy_c, input int abort_c);
    int c = 1, errs = 0;
    logic [127:0] s0 = block ^ rk[0];
    while (!ready && c < 200) begin
      if (round !== ((c == 1) ? 4'd0 : 4'((c - 2) / 5 + 1))) errs++;
      if (c >= 2 && c <= 5) chk({tag, "_sboxw"}, 128'(sboxw), 128'(32'(s0 >> (96 - 32*(c-2)))));
      if (c == 1 && !hold) next = 1'b0;
`ifdef AES_ENC_BUSY_ERR_EN
      if (c == 1) chk({tag, "_busy_init"}, 128'(busy_err), 128'(0));
      if (c == busy_c + 1) chk({tag, "_busy_pulse"}, 128'(busy_err), 128'(1));
      if (c == busy_c + 2) chk({tag, "_busy_drop"}, 128'(busy_err), 128'(0));
`endif
      if (c == busy_c) begin
        next = 1'b1;
        keylen = ~keylen;
        block = ~block;
      end
      if (c == busy_c + 1) next = 1'b0;
      if (c == abort_c) begin
        reset = 1'b1;
        @(negedge clk);
        chk({tag, "_ready"}, 128'(ready), 128'(1));
        chk({tag, "_new_block"}, new_block, 128'(0));
        chk({tag, "_round"}, 128'(round), 128'(0));
        reset = 1'b0;
        return;
      end
      @(negedge clk);
      c++;
    end
    chk({tag, "_round_seq_errs"}, 128'(errs), 128'(0));
    chk({tag, "_latency"}, 128'(c), 128'(lat));
    chk({tag, "_ct"}, new_block, exp);
    chk({tag, "_round_idle"}, 128'(round), 128'(0));
  endtask

  initial begin
    logic [7:0] inv;
    for (int i = 0; i < 256; i++) begin
      inv = 8'h01;
      for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(i));
      sb[i] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
    reset = 1'b1; next = 1'b0; keylen = 1'b0; block = '0;
    expand({KEY_B, 128'h0}, 1'b0);
    @(negedge clk); @(negedge clk);
    chk("rst_ready", 128'(ready), 128'(1));
    chk("rst_new_block", new_block, 128'(0));
    chk("rst_round", 128'(round), 128'(0));
    chk("rst_sboxw", 128'(sboxw), 128'(0));
`ifdef AES_ENC_BUSY_ERR_EN
    chk("rst_busy_err", 128'(busy_err), 128'(0));
`endif
    reset = 1'b0;
    block = PT_B; keylen = 1'b0; next = 1'b1;
    @(negedge clk);
    track("aes128", CT_B, 52, 1'b0, -5, -5);
    @(negedge clk);
    chk("idle_hold_ct", new_block, CT_B);
    chk("idle_hold_ready", 128'(ready), 128'(1));
    expand(KEY_C3, 1'b1);
    block = PT_C; keylen = 1'b1; next = 1'b1;
    @(negedge clk);
    track("aes256", CT_C3, 72, 1'b0, -5, -5);
    expand({KEY_B, 128'h0}, 1'b0);
    block = PT_B; keylen = 1'b0; next = 1'b1;
    @(negedge clk);
    track("busy", CT_B, 52, 1'b0, 20, -5);
    block = PT_B; keylen = 1'b0; next = 1'b1;
    @(negedge clk);
    track("abort", '0, 0, 1'b0, -5, 30);
    expand({KEY_C1, 128'h0}, 1'b0);
    block = PT_C; next = 1'b1;
    @(negedge clk);
    track("aes128_c1", CT_C1, 52, 1'b0, -5, -5);
    block = PT_C; next = 1'b1;
    @(negedge clk);
    track("b2b_first", CT_C1, 52, 1'b1, -5, -5);
    expand({KEY_B, 128'h0}, 1'b0);
    block = PT_B;
    @(negedge clk);
    track("b2b_second", CT_B, 52, 1'b0, -5, -5);
    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
